// File: rtl/idct_arb_pkg.sv
// Shared types and default constants for the IDCT frame arbiter.
package idct_arb_pkg;

    localparam int unsigned WDATA_DEF = 42;
    localparam int unsigned WLEN_DEF  = 12;
    localparam int unsigned LAT_DEF   = 1;

    // Saturation ceiling of the per-frame overflow counter at the default width.
    localparam logic [WLEN_DEF-1:0] OVF_MAX_DEF = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/idct_rr_pick.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the channel that was not served last.
module idct_rr_pick (
    input  logic [1:0] req,
    input  logic       last_id,
    output logic       any,
    output logic       win_id
);

    assign any    = |req;
    assign win_id = (&req) ? ~last_id : req[1];

endmodule

// File: rtl/idct_frame_arb.sv
// Frame-granular round-robin scheduler sharing one IDCT scaling datapath between two channels.
// Define IDCT_ARB_OVF_CNT_EN to build the saturating per-frame overflow counter behind done_ovf_cnt.
module idct_frame_arb
    import idct_arb_pkg::*;
#(
    parameter int unsigned wData = WDATA_DEF,
    parameter int unsigned wLen  = WLEN_DEF,
    parameter int unsigned LAT   = LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_sync,
    input  logic             req0,
    input  logic             req1,
    input  logic [wLen-1:0]  len0,
    input  logic [wLen-1:0]  len1,
    input  logic             in0_valid,
    input  logic             in1_valid,
    output logic             in0_ready,
    output logic             in1_ready,
    input  logic [wData-1:0] in0_real,
    input  logic [wData-1:0] in0_imag,
    input  logic [wData-1:0] in1_real,
    input  logic [wData-1:0] in1_imag,
    output logic             gnt0,
    output logic             gnt1,
    output logic             dp_valid,
    output logic             dp_sop,
    output logic             dp_eop,
    input  logic             dp_ready,
    output logic [wData-1:0] dp_real,
    output logic [wData-1:0] dp_imag,
    output logic [wLen-1:0]  dp_fftpts,
    input  logic             dp_overflow,
    output logic             done,
    output logic             done_id,
    output logic             done_ovf,
    output logic [wLen-1:0]  done_ovf_cnt
);

    localparam int unsigned FL_W = $clog2(LAT + 1);

    arb_state_e      state_q, state_d;
    logic            id_q, id_d;
    logic            last_id_q, last_id_d;
    logic [wLen-1:0] len_q, len_d;
    logic [wLen-1:0] cnt_q, cnt_d;
    logic [FL_W-1:0] fcnt_q, fcnt_d;
    logic            ovf_q, ovf_d;
    logic            any;
    logic            win_id;

`ifdef IDCT_ARB_OVF_CNT_EN
    localparam logic [wLen-1:0] OVF_MAX = '1;
    logic [wLen-1:0] ovf_cnt_q, ovf_cnt_d;
`endif

    idct_rr_pick u_pick (
        .req     ({req1, req0}),
        .last_id (last_id_q),
        .any     (any),
        .win_id  (win_id)
    );

    // State and frame context registers.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q   <= IDLE;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            len_q     <= '0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
            ovf_q     <= 1'b0;
`ifdef IDCT_ARB_OVF_CNT_EN
            ovf_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            fcnt_q    <= fcnt_d;
            ovf_q     <= ovf_d;
`ifdef IDCT_ARB_OVF_CNT_EN
            ovf_cnt_q <= ovf_cnt_d;
`endif
        end
    end

    // Next-state, stream mux, framing and completion reporting.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        fcnt_d    = fcnt_q;
        ovf_d     = ovf_q;
`ifdef IDCT_ARB_OVF_CNT_EN
        ovf_cnt_d = ovf_cnt_q;
`endif
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        dp_valid  = 1'b0;
        dp_sop    = 1'b0;
        dp_eop    = 1'b0;
        dp_real   = '0;
        dp_imag   = '0;
        done      = 1'b0;
        gnt0      = (state_q != IDLE) & ~id_q;
        gnt1      = (state_q != IDLE) & id_q;

        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = BURST;
                    id_d    = win_id;
                    len_d   = win_id ? len1 : len0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
`ifdef IDCT_ARB_OVF_CNT_EN
                    ovf_cnt_d = '0;
`endif
                end
            end
            BURST: begin
                dp_valid  = id_q ? in1_valid : in0_valid;
                in0_ready = ~id_q & dp_ready;
                in1_ready = id_q & dp_ready;
                dp_real   = id_q ? in1_real : in0_real;
                dp_imag   = id_q ? in1_imag : in0_imag;
                dp_sop    = dp_valid & (cnt_q == '0);
                // len 0 wraps to all-ones, i.e. a 2^wLen-sample frame.
                dp_eop    = dp_valid & (cnt_q == len_q - wLen'(1));
                if (dp_valid && dp_ready) begin
                    cnt_d = cnt_q + wLen'(1);
                    if (dp_eop) begin
                        state_d = FLUSH;
                        fcnt_d  = FL_W'(LAT);
                    end
                end
            end
            FLUSH: begin
                fcnt_d = fcnt_q - FL_W'(1);
                if (fcnt_q == FL_W'(1)) begin
                    done      = 1'b1;
                    state_d   = IDLE;
                    last_id_d = id_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Overflow seen in the completion cycle still counts toward that frame.
        if ((state_q != IDLE) && dp_overflow) begin
            ovf_d = 1'b1;
`ifdef IDCT_ARB_OVF_CNT_EN
            ovf_cnt_d = (ovf_cnt_q == OVF_MAX) ? ovf_cnt_q : ovf_cnt_q + wLen'(1);
`endif
        end

        done_id  = done & id_q;
        done_ovf = done & ovf_d;
`ifdef IDCT_ARB_OVF_CNT_EN
        done_ovf_cnt = done ? ovf_cnt_d : '0;
`else
        done_ovf_cnt = '0;
`endif
    end

    assign dp_fftpts = len_q;

endmodule

// File: tb/tb_idct_frame_arb.sv
// Directed, table-driven bench for idct_frame_arb with hand-written tie and mid-frame reset sequences.
module tb_idct_frame_arb;

    localparam int unsigned LAT = 1;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        req0, req1;
    logic [11:0] len0, len1;
    logic        in0_valid, in1_valid, in0_ready, in1_ready;
    logic [41:0] in0_real, in0_imag, in1_real, in1_imag;
    logic        gnt0, gnt1, dp_valid, dp_sop, dp_eop, dp_ready;
    logic [41:0] dp_real, dp_imag;
    logic [11:0] dp_fftpts;
    logic        dp_overflow, done, done_id, done_ovf;
    logic [11:0] done_ovf_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         ch;
        int         len;
        logic [3:0] rdy;
        logic [3:0] val;
        int         ovf_n;
    } vec_t;

    vec_t tbl[5];

    idct_frame_arb #(.wData(42), .wLen(12), .LAT(LAT)) dut (
        .clk(clk), .rst_sync(rst_sync),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .in0_valid(in0_valid), .in1_valid(in1_valid),
        .in0_ready(in0_ready), .in1_ready(in1_ready),
        .in0_real(in0_real), .in0_imag(in0_imag),
        .in1_real(in1_real), .in1_imag(in1_imag),
        .gnt0(gnt0), .gnt1(gnt1),
        .dp_valid(dp_valid), .dp_sop(dp_sop), .dp_eop(dp_eop), .dp_ready(dp_ready),
        .dp_real(dp_real), .dp_imag(dp_imag), .dp_fftpts(dp_fftpts),
        .dp_overflow(dp_overflow),
        .done(done), .done_id(done_id), .done_ovf(done_ovf), .done_ovf_cnt(done_ovf_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_vec();
        return {gnt0, gnt1, dp_valid, dp_sop, dp_eop, in0_ready, in1_ready, done, done_id, done_ovf};
    endfunction

    // One complete frame on the given channel, checked cycle by cycle from request to release.
    task automatic run_frame(input vec_t v);
        int len_eff = (v.len == 0) ? 4096 : v.len;
        int n = 0, e = -1, dn = 0, dn_cyc = -1;
        int sop_err = 0, eop_err = 0, hs_err = 0, oth_err = 0, dat_err = 0, fl_err = 0;
        int exp_cnt;
        logic d_id = 1'b0, d_ovf = 1'b0, g, gv, gr, orr, gnt_rel = 1'b1;
        logic [11:0] d_cnt = '0;
        @(negedge clk);
        if (v.ch == 1) begin req1 = 1'b1; len1 = 12'(v.len); end
        else begin req0 = 1'b1; len0 = 12'(v.len); end
        #1;
        check("gnt_before_grant", (v.ch == 1) ? gnt1 : gnt0, 0);
        for (int cyc = 0; cyc < len_eff * 4 + 20; cyc++) begin
            @(negedge clk);
            req0 = 1'b0;
            req1 = 1'b0;
            gv = (e < 0) ? v.val[cyc % 4] : 1'b1;
            in0_valid = (v.ch == 1) ? 1'b1 : gv;
            in1_valid = (v.ch == 1) ? gv : 1'b1;
            dp_ready  = (e < 0) ? v.rdy[cyc % 4] : 1'b1;
            in0_real = 42'(1000 + cyc);
            in0_imag = 42'(3000 + cyc);
            in1_real = 42'(5000 + cyc);
            in1_imag = 42'(7000 + cyc);
            dp_overflow = (v.ovf_n > 0) &&
                          ((e < 0 && cyc < v.ovf_n - 1) || (e >= 0 && cyc == e + int'(LAT)));
            #1;
            g   = (v.ch == 1) ? gnt1 : gnt0;
            gr  = (v.ch == 1) ? in1_ready : in0_ready;
            orr = (v.ch == 1) ? in0_ready : in1_ready;
            if (cyc == 0) begin
                check("gnt_latency", g, 1);
                check("fftpts", dp_fftpts, v.len);
            end
            if (orr) oth_err++;
            if (done) begin
                dn++;
                dn_cyc = cyc;
                d_id   = done_id;
                d_ovf  = done_ovf;
                d_cnt  = done_ovf_cnt;
            end
            if (e < 0) begin
                if (dp_valid != gv || gr != dp_ready) hs_err++;
                if (dp_sop != (dp_valid && n == 0)) sop_err++;
                if (dp_eop != (dp_valid && n == len_eff - 1)) eop_err++;
                if (dp_valid && (dp_real != ((v.ch == 1) ? in1_real : in0_real) ||
                                 dp_imag != ((v.ch == 1) ? in1_imag : in0_imag))) dat_err++;
                if (dp_valid && dp_ready) begin
                    if (n == len_eff - 1) e = cyc;
                    n++;
                end
            end else begin
                if (dp_valid || gr || dp_sop || dp_eop) fl_err++;
                if (cyc == e + int'(LAT) + 1) begin
                    gnt_rel = g;
                    break;
                end
            end
        end
        dp_overflow = 1'b0;
`ifdef IDCT_ARB_OVF_CNT_EN
        exp_cnt = v.ovf_n;
`else
        exp_cnt = 0;
`endif
        check("transfers", n, len_eff);
        check("sop_errors", sop_err, 0);
        check("eop_errors", eop_err, 0);
        check("burst_handshake", hs_err, 0);
        check("other_ready", oth_err, 0);
        check("data_mux", dat_err, 0);
        check("flush_quiet", fl_err, 0);
        check("done_count", dn, 1);
        check("done_cycle", dn_cyc, e + int'(LAT));
        check("done_id", d_id, v.ch);
        check("done_ovf", d_ovf, (v.ovf_n > 0) ? 1 : 0);
        check("done_ovf_cnt", d_cnt, exp_cnt);
        check("gnt_release", gnt_rel, 0);
    endtask

    initial begin
        int sops = 0, eops = 0, dones = 0, n = 0, late_done = 0;
        int sop_cyc[3];
        int eop_cyc[3];
        logic sop_id[3];

        tbl[0] = '{0, 4, 4'b1111, 4'b1111, 0};
        tbl[1] = '{1, 8, 4'b1001, 4'b1011, 0};
        tbl[2] = '{0, 5, 4'b1111, 4'b1111, 3};
        tbl[3] = '{1, 1, 4'b1111, 4'b1111, 0};
        tbl[4] = '{0, 0, 4'b1111, 4'b1111, 0};
        for (int i = 0; i < 3; i++) begin
            sop_cyc[i] = 0;
            eop_cyc[i] = 0;
            sop_id[i]  = 1'b0;
        end

        // Reset with busy-looking inputs: every output must read 0.
        rst_sync = 1'b1;
        req0 = 1'b0; req1 = 1'b0; len0 = 12'd3; len1 = 12'd5;
        in0_valid = 1'b1; in1_valid = 1'b1; dp_ready = 1'b1; dp_overflow = 1'b1;
        in0_real = 42'd11; in0_imag = 42'd12; in1_real = 42'd13; in1_imag = 42'd14;
        repeat (3) @(negedge clk);
        rst_sync = 1'b0;
        dp_overflow = 1'b0;
        #1;
        check("reset_ctrl", ctrl_vec(), 0);
        check("reset_data", dp_real | dp_imag, 0);
        check("reset_fftpts", dp_fftpts, 0);
        check("reset_ovf_cnt", done_ovf_cnt, 0);

        // Tie from reset: ch0, ch1, ch0 with LAT+2 cycles from eop to the next sop.
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; len0 = 12'd2; len1 = 12'd2;
        for (int cyc = 0; cyc < 60 && dones < 3; cyc++) begin
            @(negedge clk);
            #1;
            if (dp_valid && dp_ready && dp_sop && sops < 3) begin
                sop_cyc[sops] = cyc;
                sop_id[sops]  = gnt1;
                sops++;
                if (sops == 3) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
            if (dp_valid && dp_ready && dp_eop && eops < 3) begin
                eop_cyc[eops] = cyc;
                eops++;
            end
            if (done) dones++;
        end
        check("tie_frames", dones, 3);
        check("tie_id0", sop_id[0], 0);
        check("tie_id1", sop_id[1], 1);
        check("tie_id2", sop_id[2], 0);
        check("tie_gap1", sop_cyc[1] - eop_cyc[0], int'(LAT) + 2);
        check("tie_gap2", sop_cyc[2] - eop_cyc[1], int'(LAT) + 2);

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // Reset after 3 of 8 samples: frame abandoned, no done, then ch1 served.
        @(negedge clk);
        req0 = 1'b1; len0 = 12'd8; in0_valid = 1'b1; dp_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            @(negedge clk);
            req0 = 1'b0;
            #1;
            if (dp_valid && dp_ready) n++;
        end
        check("pre_reset_xfers", n, 3);
        @(negedge clk);
        in0_valid = 1'b0;
        rst_sync  = 1'b1;
        @(negedge clk);
        rst_sync  = 1'b0;
        in0_valid = 1'b1;
        #1;
        check("midreset_ctrl", ctrl_vec(), 0);
        check("midreset_fftpts", dp_fftpts, 0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            #1;
            if (done || gnt0 || gnt1) late_done++;
        end
        check("midreset_quiet", late_done, 0);
        run_frame('{1, 2, 4'b1111, 4'b1111, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
